// File: rtl/lr_inference_sequencer.sv
// Sequential N-feature logistic-regression scorer: one signed MAC per cycle over paired BRAM words, then bias add and >0 threshold.
// Optional accumulator saturation is enabled by defining LR_ACC_SAT_EN (default: two's-complement wrap, sat_flag tied 0).
module lr_inference_sequencer #(
  parameter int DATA_WIDTH   = 32,
  parameter int ACC_WIDTH    = 72,
  parameter int MAX_FEATURES = 64,
  parameter int ADDR_WIDTH   = 6,
  parameter int FRAC_BITS    = 0
) (
  input  logic                  S_AXI_ACLK,
  input  logic                  S_AXI_ARESET,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   len,
  input  logic [DATA_WIDTH-1:0] bias,
  input  logic                  abort,
  output logic                  mem_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] w_rdata,
  input  logic [DATA_WIDTH-1:0] x_rdata,
  output logic                  busy,
  output logic                  done,
  output logic [ACC_WIDTH-1:0]  score,
  output logic                  result,
  output logic                  sat_flag
);

`ifdef LR_ACC_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  localparam logic [ADDR_WIDTH:0]          MAX_LEN  = (ADDR_WIDTH+1)'(MAX_FEATURES);
  localparam logic [ADDR_WIDTH:0]          LEN_ONE  = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0]        ADDR_ONE = ADDR_WIDTH'(1);
  localparam logic signed [ACC_WIDTH-1:0]  ACC_MAX  = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0]  ACC_MIN  = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, RUN, DRAIN, FINAL, DONE} state_t;

  state_t                         state_q, state_d;
  logic [ADDR_WIDTH:0]            len_q;
  logic [ADDR_WIDTH:0]            len_clamped;
  logic [ADDR_WIDTH-1:0]          addr_q;
  logic signed [DATA_WIDTH-1:0]   bias_q;
  logic signed [ACC_WIDTH-1:0]    acc_q;
  logic                           vld_q;
  logic                           sat_job_q;
  logic                           start_ok;
  logic                           last_addr;

  logic signed [DATA_WIDTH-1:0]   w_s, x_s;
  logic signed [2*DATA_WIDTH-1:0] prod;
  logic signed [ACC_WIDTH-1:0]    prod_ext, bias_ext;
  logic [ACC_WIDTH:0]             acc_add, fin_add;

  // Returns {clipped, sum}; clipping only reported when saturation is built in.
  function automatic logic [ACC_WIDTH:0] sat_add(input logic signed [ACC_WIDTH-1:0] a,
                                                 input logic signed [ACC_WIDTH-1:0] b);
    logic signed [ACC_WIDTH-1:0] s;
    logic                        ov;
    s  = a + b;
    ov = (a[ACC_WIDTH-1] == b[ACC_WIDTH-1]) && (s[ACC_WIDTH-1] != a[ACC_WIDTH-1]);
    if (SAT_EN && ov) s = a[ACC_WIDTH-1] ? ACC_MIN : ACC_MAX;
    return {ov & SAT_EN, s};
  endfunction

  assign len_clamped = (len > MAX_LEN) ? MAX_LEN : len;
  assign start_ok    = (state_q == IDLE) && start && !abort;
  assign last_addr   = ({1'b0, addr_q} == (len_q - LEN_ONE));

  assign w_s      = $signed(w_rdata);
  assign x_s      = $signed(x_rdata);
  assign prod     = (2*DATA_WIDTH)'(w_s) * (2*DATA_WIDTH)'(x_s);
  assign prod_ext = ACC_WIDTH'(prod);
  assign bias_ext = ACC_WIDTH'(bias_q) <<< FRAC_BITS;
  assign acc_add  = sat_add(acc_q, prod_ext);
  assign fin_add  = sat_add(acc_q, bias_ext);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_ok) state_d = (len_clamped != '0) ? RUN : FINAL;
      RUN:     if (last_addr) state_d = DRAIN;
      DRAIN:   state_d = FINAL;
      FINAL:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort) state_d = IDLE;
  end

  assign mem_en   = (state_q == RUN) && !abort;
  assign mem_addr = (state_q == RUN) ? addr_q : '0;
  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      state_q   <= IDLE;
      len_q     <= '0;
      addr_q    <= '0;
      bias_q    <= '0;
      acc_q     <= '0;
      vld_q     <= 1'b0;
      sat_job_q <= 1'b0;
      score     <= '0;
      result    <= 1'b0;
      sat_flag  <= 1'b0;
    end else begin
      state_q <= state_d;
      // Read data returns one cycle after the enable; an abort kills it in flight.
      vld_q   <= mem_en;
      if (start_ok) begin
        len_q     <= len_clamped;
        bias_q    <= $signed(bias);
        addr_q    <= '0;
        acc_q     <= '0;
        sat_job_q <= 1'b0;
      end else begin
        if (mem_en) addr_q <= addr_q + ADDR_ONE;
        if (vld_q && !abort) begin
          acc_q <= acc_add[ACC_WIDTH-1:0];
          if (acc_add[ACC_WIDTH]) sat_job_q <= 1'b1;
        end
      end
      // Published results change only on completion, so an aborted job leaves them untouched.
      if (state_q == FINAL && !abort) begin
        score    <= fin_add[ACC_WIDTH-1:0];
        result   <= !fin_add[ACC_WIDTH-1] && (fin_add[ACC_WIDTH-1:0] != '0);
        sat_flag <= sat_job_q | fin_add[ACC_WIDTH];
      end
    end
  end

endmodule
